// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out reads have absolute priority with a
// fixed 3-cycle latency; CPU accesses wait in a one-entry holding register for a free slot.
module vram_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // display pixel fetch
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  // CPU peripheral bus
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // stall statistics
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  // VRAM macro
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // RD_WAIT covers the RAM access cycle so that RD samples ram_rdata when it is valid.
  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_RD_WAIT,
    S_RD
  } state_e;

  state_e              state_q, state_d;
  logic                hold_we_q, hold_we_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [1:0]          disp_pipe_q, disp_pipe_d;
  logic                disp_rvalid_q, disp_rvalid_d;
  logic [DATA_W-1:0]   disp_rdata_q, disp_rdata_d;
  logic                cpu_issue;
  logic                stall_inc;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    cpu_ack_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    stall_inc    = 1'b0;

    cpu_issue = (state_q == S_PEND) && !disp_req;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          hold_we_d    = cpu_we;
          hold_addr_d  = cpu_addr;
          hold_wdata_d = cpu_wdata;
          cpu_ack_d    = 1'b1;
          state_d      = S_PEND;
        end
      end
      S_PEND: begin
        if (cpu_issue) state_d = hold_we_q ? S_IDLE : S_RD_WAIT;
        else           stall_inc = 1'b1;
      end
      S_RD_WAIT: state_d = S_RD;
      S_RD: begin
        cpu_rdata_d  = ram_rdata;
        cpu_rvalid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Slot decision: display first, then a pending CPU access; address/data hold when idle.
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (disp_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = disp_addr;
    end else if (cpu_issue) begin
      ram_en_d   = 1'b1;
      ram_we_d   = hold_we_q;
      ram_addr_d = hold_addr_q;
      if (hold_we_q) ram_wdata_d = hold_wdata_q;
    end

    if (stall_clr)                      stall_cnt_d = '0;
    else if (stall_inc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else                                stall_cnt_d = stall_cnt_q;

    // Display pipeline: [0] = RAM access cycle, [1] = ram_rdata valid cycle.
    disp_pipe_d   = {disp_pipe_q[0], disp_req};
    disp_rvalid_d = disp_pipe_q[1];
    disp_rdata_d  = disp_pipe_q[1] ? ram_rdata : disp_rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hold_we_q     <= 1'b0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      stall_cnt_q   <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      disp_pipe_q   <= '0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      hold_we_q     <= hold_we_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      stall_cnt_q   <= stall_cnt_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      disp_pipe_q   <= disp_pipe_d;
      disp_rvalid_q <= disp_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
    end
  end

  assign disp_rvalid = disp_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign stall_cnt   = stall_cnt_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;

endmodule
